// File: rtl/avalon_msg_limiter_pkg.sv
// Shared types for the Avalon-ST message length limiter.
`timescale 1ns/1ps
package avalon_msg_limiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IN_MSG,
        DROP
    } msg_lim_state_t;

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST beat bundle shared by the enforcer and limiter stages.
`timescale 1ns/1ps
interface avalon_st_if #(
    parameter int DATA_WIDTH_IN_BYTES = 16
);
    // A one-byte beat still carries a 1-bit empty field so the port never vanishes.
    localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

    logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
    logic                             valid;
    logic                             sop;
    logic                             eop;
    logic [EMPTY_W-1:0]               empty;
    logic                             rdy;

    modport master (output data, valid, sop, eop, empty, input rdy);
    modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/avalon_msg_limiter.sv
// Caps each Avalon-ST message at MAX_MSG_WORDS beats, forcing eop on the last
// permitted beat and silently draining the rest of an over-long message.
`timescale 1ns/1ps
module avalon_msg_limiter
    import avalon_msg_limiter_pkg::*;
#(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int MAX_MSG_WORDS       = 64
) (
    input  logic                                 clk,
    input  logic                                 rst,
    avalon_st_if.slave                           enforced_msg,
    avalon_st_if.master                          limited_msg,
    output logic                                 truncated_indi,
    output logic [$clog2(MAX_MSG_WORDS+1)-1:0]   msg_len_words,
    output logic                                 msg_len_vld
);

    localparam int                 CNT_W     = $clog2(MAX_MSG_WORDS + 1);
    localparam logic [CNT_W-1:0]   LIMIT_IDX = CNT_W'(MAX_MSG_WORDS - 1);

    msg_lim_state_t   state;
    msg_lim_state_t   next_state;
    logic [CNT_W-1:0] word_cnt;
    logic             at_limit;
    logic             force_eop;
    logic             out_xfer;

    // A limit beat that already carries eop is a natural end, not a truncation.
    assign at_limit = (word_cnt == LIMIT_IDX) && !enforced_msg.eop;
    assign out_xfer = limited_msg.valid && limited_msg.rdy;

    // NOTE: every output of this block is given a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state         = state;
        force_eop          = 1'b0;
        limited_msg.data   = enforced_msg.data;
        limited_msg.sop    = enforced_msg.sop;
        limited_msg.eop    = enforced_msg.eop;
        limited_msg.empty  = enforced_msg.empty;
        limited_msg.valid  = enforced_msg.valid;
        enforced_msg.rdy   = limited_msg.rdy;

        if (rst) begin
            limited_msg.valid = 1'b0;
            enforced_msg.rdy  = 1'b0;
        end else begin
            case (state)
                IDLE, IN_MSG: begin
                    if (at_limit) begin
                        force_eop         = 1'b1;
                        limited_msg.eop   = 1'b1;
                        limited_msg.empty = '0;
                    end
                    if (enforced_msg.valid && limited_msg.rdy) begin
                        if (force_eop) begin
                            next_state = DROP;
                        end else if (enforced_msg.eop) begin
                            next_state = IDLE;
                        end else begin
                            next_state = IN_MSG;
                        end
                    end
                end
                DROP: begin
                    limited_msg.valid = 1'b0;
                    enforced_msg.rdy  = 1'b1;
                    if (enforced_msg.valid && enforced_msg.eop) begin
                        next_state = IDLE;
                    end
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            word_cnt       <= '0;
            truncated_indi <= 1'b0;
            msg_len_words  <= '0;
            msg_len_vld    <= 1'b0;
        end else begin
            state          <= next_state;
            truncated_indi <= 1'b0;
            msg_len_vld    <= 1'b0;
            if (out_xfer) begin
                if (limited_msg.eop) begin
                    msg_len_words  <= word_cnt + CNT_W'(1);
                    msg_len_vld    <= 1'b1;
                    truncated_indi <= force_eop;
                    word_cnt       <= '0;
                end else begin
                    word_cnt <= word_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_avalon_msg_limiter.sv
// Directed bench for avalon_msg_limiter: two instances (limit 4 and limit 1)
// checked every cycle against a message-level model of the length cap.
`timescale 1ns/1ps
module tb_avalon_msg_limiter;

    typedef struct {
        logic [127:0] data;
        logic         sop;
        logic         eop;
        logic [3:0]   empty;
    } beat_t;

    typedef struct {
        int len;
        bit trunc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ds_rdy = 1'b1;
    bit   stall_mode = 1'b0;

    always #5 clk = ~clk;

    logic         i_valid [2];
    logic         i_sop   [2];
    logic         i_eop   [2];
    logic [127:0] i_data  [2];
    logic [3:0]   i_empty [2];
    logic         i_rdy   [2];
    logic         o_valid [2];
    logic         o_sop   [2];
    logic         o_eop   [2];
    logic [127:0] o_data  [2];
    logic [3:0]   o_empty [2];
    logic         o_trunc [2];
    logic         o_lvld  [2];
    logic [7:0]   o_len   [2];
    logic [2:0]   len4;
    logic [0:0]   len1;

    avalon_st_if #(.DATA_WIDTH_IN_BYTES(16)) in4 ();
    avalon_st_if #(.DATA_WIDTH_IN_BYTES(16)) out4 ();
    avalon_st_if #(.DATA_WIDTH_IN_BYTES(16)) in1 ();
    avalon_st_if #(.DATA_WIDTH_IN_BYTES(16)) out1 ();

    assign in4.data  = i_data[0];
    assign in4.valid = i_valid[0];
    assign in4.sop   = i_sop[0];
    assign in4.eop   = i_eop[0];
    assign in4.empty = i_empty[0];
    assign i_rdy[0]  = in4.rdy;
    assign out4.rdy  = ds_rdy;
    assign o_data[0]  = out4.data;
    assign o_valid[0] = out4.valid;
    assign o_sop[0]   = out4.sop;
    assign o_eop[0]   = out4.eop;
    assign o_empty[0] = out4.empty;
    assign o_len[0]   = 8'(len4);

    assign in1.data  = i_data[1];
    assign in1.valid = i_valid[1];
    assign in1.sop   = i_sop[1];
    assign in1.eop   = i_eop[1];
    assign in1.empty = i_empty[1];
    assign i_rdy[1]  = in1.rdy;
    assign out1.rdy  = ds_rdy;
    assign o_data[1]  = out1.data;
    assign o_valid[1] = out1.valid;
    assign o_sop[1]   = out1.sop;
    assign o_eop[1]   = out1.eop;
    assign o_empty[1] = out1.empty;
    assign o_len[1]   = 8'(len1);

    avalon_msg_limiter #(.DATA_WIDTH_IN_BYTES(16), .MAX_MSG_WORDS(4)) dut4 (
        .clk            (clk),
        .rst            (rst),
        .enforced_msg   (in4),
        .limited_msg    (out4),
        .truncated_indi (o_trunc[0]),
        .msg_len_words  (len4),
        .msg_len_vld    (o_lvld[0])
    );

    avalon_msg_limiter #(.DATA_WIDTH_IN_BYTES(16), .MAX_MSG_WORDS(1)) dut1 (
        .clk            (clk),
        .rst            (rst),
        .enforced_msg   (in1),
        .limited_msg    (out1),
        .truncated_indi (o_trunc[1]),
        .msg_len_words  (len1),
        .msg_len_vld    (o_lvld[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Downstream ready: constant 1, or toggling every cycle while stall_mode is set.
    always begin
        @(posedge clk);
        #1;
        if (stall_mode) ds_rdy = ~ds_rdy;
        else            ds_rdy = 1'b1;
    end

    // Model: expected output beats and expected end-of-message events per instance.
    beat_t exp_beats [2][$];
    ev_t   exp_ev    [2][$];
    int    trunc_seen[2] = '{0, 0};
    int    len_seen  [2] = '{0, 0};

    function automatic logic [127:0] mk_data(input int id, input int k);
        return {32'(id), 32'(k), 64'hC0DE_0000_0000_0000 ^ 64'(id * 256 + k)};
    endfunction

    // Compare process
    bit    pend      [2] = '{0, 0};
    ev_t   pend_ev   [2];
    bit    prev_stall[2] = '{0, 0};
    beat_t prev_beat [2];
    bit    nxt;
    ev_t   nev;
    beat_t eb;

    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (rst) begin
                check($sformatf("rst_valid[%0d]", s), o_valid[s], 1'b0);
                check($sformatf("rst_rdy[%0d]", s), i_rdy[s], 1'b0);
                pend[s]       = 1'b0;
                prev_stall[s] = 1'b0;
            end else begin
                nxt = 1'b0;
                nev = '{0, 1'b0};
                if (pend[s]) begin
                    check($sformatf("len_vld[%0d]", s), o_lvld[s], 1'b1);
                    check($sformatf("len_words[%0d]", s), o_len[s], pend_ev[s].len);
                    check($sformatf("trunc[%0d]", s), o_trunc[s], pend_ev[s].trunc);
                end else begin
                    check($sformatf("len_vld_idle[%0d]", s), o_lvld[s], 1'b0);
                    check($sformatf("trunc_idle[%0d]", s), o_trunc[s], 1'b0);
                end
                if (o_lvld[s] === 1'b1)  len_seen[s]++;
                if (o_trunc[s] === 1'b1) trunc_seen[s]++;
                if (prev_stall[s]) begin
                    check($sformatf("hold_valid[%0d]", s), o_valid[s], 1'b1);
                    check($sformatf("hold_data[%0d]", s), o_data[s], prev_beat[s].data);
                    check($sformatf("hold_sop[%0d]", s), o_sop[s], prev_beat[s].sop);
                    check($sformatf("hold_eop[%0d]", s), o_eop[s], prev_beat[s].eop);
                    check($sformatf("hold_empty[%0d]", s), o_empty[s], prev_beat[s].empty);
                end
                if (o_valid[s] && ds_rdy) begin
                    if (exp_beats[s].size() == 0) begin
                        check($sformatf("unexpected_beat[%0d]", s), 1'b1, 1'b0);
                    end else begin
                        eb = exp_beats[s].pop_front();
                        check($sformatf("beat_data[%0d]", s), o_data[s], eb.data);
                        check($sformatf("beat_sop[%0d]", s), o_sop[s], eb.sop);
                        check($sformatf("beat_eop[%0d]", s), o_eop[s], eb.eop);
                        check($sformatf("beat_empty[%0d]", s), o_empty[s], eb.empty);
                    end
                    if (o_eop[s]) begin
                        if (exp_ev[s].size() == 0) begin
                            check($sformatf("unexpected_eop[%0d]", s), 1'b1, 1'b0);
                        end else begin
                            nev = exp_ev[s].pop_front();
                            nxt = 1'b1;
                        end
                    end
                end
                pend[s]            = nxt;
                pend_ev[s]         = nev;
                prev_stall[s]      = o_valid[s] && !ds_rdy;
                prev_beat[s].data  = o_data[s];
                prev_beat[s].sop   = o_sop[s];
                prev_beat[s].eop   = o_eop[s];
                prev_beat[s].empty = o_empty[s];
            end
        end
    end

    // Sends an n-beat message to instance s; abort_after>0 resets the block
    // after that many beats have been accepted.
    task automatic send_msg(input int s, input int id, input int n,
                            input int last_empty, input int abort_after);
        int    m;
        int    sent;
        int    emit;
        int    budget;
        bit    got;
        bit    first;
        bit    in_eop;
        beat_t b;
        ev_t   e;

        m    = (s == 0) ? 4 : 1;
        sent = (abort_after > 0) ? abort_after : n;
        emit = (sent < m) ? sent : m;
        for (int k = 0; k < emit; k++) begin
            in_eop  = (k == n - 1);
            b.data  = mk_data(id, k);
            b.sop   = (k == 0);
            b.eop   = in_eop || (k == m - 1);
            b.empty = (k == m - 1 && !in_eop) ? 4'd0 : (in_eop ? 4'(last_empty) : 4'd3);
            exp_beats[s].push_back(b);
        end
        if (abort_after == 0) begin
            e.len   = emit;
            e.trunc = (n > m);
            exp_ev[s].push_back(e);
        end

        for (int k = 0; k < sent; k++) begin
            i_valid[s] = 1'b1;
            i_data[s]  = mk_data(id, k);
            i_sop[s]   = (k == 0);
            i_eop[s]   = (k == n - 1);
            i_empty[s] = (k == n - 1) ? 4'(last_empty) : 4'd3;
            got    = 1'b0;
            first  = 1'b1;
            budget = 0;
            while (!got && budget < 200) begin
                @(negedge clk);
                if (first && k >= m) check($sformatf("drop_rdy[%0d]", s), i_rdy[s], 1'b1);
                first = 1'b0;
                got   = i_valid[s] && i_rdy[s];
                @(posedge clk);
                #1;
                budget++;
            end
            if (!got) check($sformatf("accept_timeout[%0d]", s), 1'b0, 1'b1);
        end

        if (abort_after > 0) begin
            i_data[s]  = mk_data(id, sent);
            i_sop[s]   = 1'b0;
            i_eop[s]   = 1'b0;
            rst        = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
        end
        i_valid[s] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            i_valid[s] = 1'b0;
            i_sop[s]   = 1'b0;
            i_eop[s]   = 1'b0;
            i_data[s]  = '0;
            i_empty[s] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_len4", o_len[0], 0);
        check("reset_len1", o_len[1], 0);
        @(posedge clk);
        #1;

        // Limit 4: short, long, exact-fit, follow-on short
        send_msg(0, 1, 3, 5, 0);
        check("lit_len_3beat", o_len[0], 3);
        send_msg(0, 2, 7, 6, 0);
        check("lit_len_7beat", o_len[0], 4);
        check("lit_trunc_count_a", trunc_seen[0], 1);
        send_msg(0, 3, 4, 2, 0);
        check("lit_len_4beat", o_len[0], 4);
        check("lit_trunc_count_b", trunc_seen[0], 1);
        send_msg(0, 4, 2, 1, 0);
        check("lit_len_2beat", o_len[0], 2);

        // Limit 4 with downstream ready toggling
        stall_mode = 1'b1;
        send_msg(0, 5, 7, 7, 0);
        stall_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("lit_len_stalled", o_len[0], 4);

        // Limit 1: one-beat message, then a 3-beat message
        send_msg(1, 6, 1, 2, 0);
        check("lit_len_m1_single", o_len[1], 1);
        send_msg(1, 7, 3, 4, 0);
        check("lit_len_m1_trunc", o_len[1], 1);
        check("lit_trunc_m1", trunc_seen[1], 1);

        // Reset after beat 2, then a fresh 2-beat message
        send_msg(0, 8, 5, 0, 2);
        @(negedge clk);
        check("len_after_rst", o_len[0], 0);
        @(posedge clk);
        #1;
        send_msg(0, 9, 2, 9, 0);
        check("lit_len_after_abort", o_len[0], 2);

        check("total_len_pulses4", len_seen[0], 6);
        check("total_trunc4", trunc_seen[0], 2);
        check("total_len_pulses1", len_seen[1], 2);
        check("total_trunc1", trunc_seen[1], 1);
        check("leftover_beats4", exp_beats[0].size(), 0);
        check("leftover_beats1", exp_beats[1].size(), 0);
        check("leftover_ev4", exp_ev[0].size(), 0);
        check("leftover_ev1", exp_ev[1].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
